// File: rtl/fpu_pkg.sv
// Shared definitions for the integer-to-float converter.
// The FSM states and exponent constants live here so that the RTL and the bench agree on them.
package fpu_pkg;

    typedef enum logic [2:0] {
        GET_A,
        CONVERT,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_e;

    localparam logic [7:0] EXP_BIAS = 8'd127;
    localparam logic [7:0] EXP_BASE = 8'd158;

endpackage

// File: rtl/lzc32.sv
// Combinational leading-zero counter for a 32-bit word.
// An all-zero input yields a count of 32.
module lzc32 (
    input  logic [31:0] value_i,
    output logic [5:0]  count_o
);

    // The highest set bit is visited last, so its count is the one that remains.
    always_comb begin
        count_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value_i[i]) begin
                count_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_flt.sv
// Multi-cycle conversion of a signed or unsigned 32-bit integer to an IEEE-754 single.
// A strobe/ack handshake is used on both sides, and only one conversion is in flight at a time.
module int_to_flt
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_is_unsigned,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_e      state_q, state_d;
    logic        ack_q;
    logic        zstb_q;
    logic [31:0] z_q;

    logic [31:0] a_q;
    logic        unsigned_q;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [31:0] norm_q;
    logic [7:0]  exp_q;
    logic [22:0] frac_q;

    logic [31:0] magAbs;
    logic [5:0]  lz;
    logic        roundUp;
    logic [23:0] fracSum;

    lzc32 u_lzc (
        .value_i (mag_q),
        .count_o (lz)
    );

    assign magAbs = (a_q[31] && !unsigned_q) ? (~a_q + 32'd1) : a_q;

    // The fraction carry-out equals the mantissa carry-out because the leading bit is always one.
    assign roundUp = norm_q[7] & (norm_q[6] | (|norm_q[5:0]) | norm_q[8]);
    assign fracSum = {1'b0, norm_q[30:8]} + {23'd0, roundUp};

    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_A:     if (input_a_stb && ack_q) state_d = CONVERT;
            CONVERT:   state_d = NORMALISE;
            NORMALISE: state_d = ROUND;
            ROUND:     state_d = PACK;
            PACK:      state_d = PUT_Z;
            PUT_Z:     if (output_z_ack && zstb_q) state_d = GET_A;
            default:   state_d = GET_A;
        endcase
    end

    // The handshake flags are registered from the next state so that they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            ack_q   <= 1'b0;
            zstb_q  <= 1'b0;
            z_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == GET_A);
            zstb_q  <= (state_d == PUT_Z);
            if (state_q == PACK) begin
                z_q <= norm_q[31] ? {sign_q, exp_q, frac_q} : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state_q)
            GET_A: begin
                if (input_a_stb && ack_q) begin
                    a_q        <= input_a;
                    unsigned_q <= input_a_is_unsigned;
                end
            end
            CONVERT: begin
                sign_q <= a_q[31] & ~unsigned_q;
                mag_q  <= magAbs;
            end
            NORMALISE: begin
                norm_q <= mag_q << lz;
                exp_q  <= EXP_BASE - {2'b00, lz};
            end
            ROUND: begin
                frac_q <= fracSum[22:0];
                if (fracSum[23]) begin
                    exp_q <= exp_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign input_a_ack  = ack_q;
    assign output_z     = z_q;
    assign output_z_stb = zstb_q;

endmodule

// File: doc/int_to_flt.md
INT_TO_FLT -- requirements
Module: int_to_flt

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- input_a  in  32  integer operand
- input_a_is_unsigned  in  1  1 = fcvt.s.wu, 0 = fcvt.s.w
- input_a_stb  in  1  operand valid
- input_a_ack  out  1  block ready to accept operand
- output_z  out  32  IEEE-754 single result
- output_z_stb  out  1  result valid
- output_z_ack  in  1  consumer accepts result

Function
REQ-003 Handshakes: an operand SHALL transfer on a rising edge where input_a_stb && input_a_ack; a result SHALL transfer on a rising edge where output_z_stb && output_z_ack.
REQ-004 The FSM SHALL have states GET_A, CONVERT, NORMALISE, ROUND, PACK, PUT_Z, in that order, with PUT_Z returning to GET_A.
REQ-005 input_a_ack SHALL be 1 only in GET_A; it SHALL be 0 the cycle after an operand transfer.
REQ-006 On transfer, input_a and input_a_is_unsigned SHALL be registered; later input changes SHALL NOT affect the result.
REQ-007 CONVERT: sign = input_a[31] & ~is_unsigned; magnitude = two's-complement absolute value if signed, raw value if unsigned, as a 32-bit unsigned quantity (0x80000000 signed gives magnitude 0x80000000).
REQ-008 NORMALISE: leading-zero count lz of magnitude, computed in one cycle; magnitude shifted left by lz; biased exponent = 158 - lz.
REQ-009 ROUND: round-to-nearest-even on the 24-bit mantissa using guard bit, round bit and sticky OR of the remaining bits.
- A mantissa carry-out SHALL increment the exponent and clear the mantissa.
REQ-010 PACK: output_z = {sign, exponent[7:0], mantissa[22:0]}.
- A zero magnitude SHALL yield exactly 0x00000000 (never -0).
REQ-011 Latency: with an operand transfer at edge T, output_z_stb SHALL be 1 after edge T+4, for every operand including zero.
REQ-012 PUT_Z: output_z_stb = 1; output_z SHALL stay stable while output_z_ack = 0.
- On transfer, output_z_stb SHALL drop after that edge and the FSM SHALL enter GET_A, giving input_a_ack = 1 the next cycle.
REQ-013 Throughput: at most one conversion in flight; new operands SHALL be refused (input_a_ack = 0) from CONVERT through PUT_Z.
REQ-014 NaN, infinity and denormal outputs SHALL never occur; no exception flags are produced.

Reset
REQ-015 With rst = 1 at a rising edge: state <= GET_A; output_z_stb <= 0; input_a_ack <= 0; output_z <= 0x00000000.
REQ-016 Reset SHALL abort any conversion in progress, including PUT_Z, and discard the pending result.
REQ-017 input_a_ack SHALL rise the first cycle after rst deasserts.

Structure
REQ-018 The FSM state enum and the constants EXP_BIAS = 127 and EXP_BASE = 158 SHALL reside in the shared package fpu_pkg.
REQ-019 Leading-zero counting SHALL be one combinational sub-module, lzc32 (32-bit input, 6-bit count, count 32 for zero).

Verification
REQ-020 Signed 2 -> 0x40000000; signed 5 -> 0x40A00000; output_z_stb high exactly 4 cycles after the operand handshake.
REQ-021 Signed 0xFFFFFFFF (-1) -> 0xBF800000; signed 0x80000000 -> 0xCF000000; signed 0 -> 0x00000000.
REQ-022 Unsigned 0xFFFFFFFF -> 0x4F800000 (round carry increments the exponent); unsigned 0x80000000 -> 0x4F000000.
REQ-023 Ties: 0x01000001 -> 0x4B800000 (rounds to even, down); 0x01000003 -> 0x4B800002 (rounds to even, up).
REQ-024 Back-pressure and reset:
- Hold output_z_ack = 0 for 5 cycles: output_z and output_z_stb stay stable and input_a_ack stays 0.
- Assert rst during NORMALISE: output_z_stb never rises for that operand; the next operand converts correctly.
